dmem_arbiter: RTL

- Shares the single-port data BRAM between two requesters: the CPU mem/wb stage and the NN accelerator's load/store port.
- Sits between the CPU `dmem_*` pins, the accelerator memory master and the BRAM macro.
- CPU has fixed priority. A starvation counter forces periodic accelerator grants, and the CPU is stalled during those cycles.
- The block returns read data, tagged by owner, one cycle after each read.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arb_starve.sv | 56 +++++
 rtl/dmem_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DMEM_ADDR_W = 16;
  localparam int unsigned DMEM_DATA_W = 16;
  localparam int unsigned STARVE_W    = 8;

  // Owner of the read issued in the previous cycle.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_ACC = 1'b1
  } owner_t;

  // Starvation tracker state.
  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_arb_starve.sv
// Starvation counter: after STARVE_MAX consecutive denied accelerator
// request cycles, raises force_acc for exactly one cycle.
module dmem_arb_starve
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic acc_req,
  input  logic acc_gnt,
  output logic force_acc
);

  localparam logic [STARVE_W-1:0] CNT_LAST = STARVE_W'(STARVE_MAX - 1);

  arb_state_t          state;
  logic [STARVE_W-1:0] starve_cnt;

  // Count denied request cycles; one forced cycle then back to normal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_NORMAL;
      starve_cnt <= '0;
      force_acc  <= 1'b0;
    end else begin
      case (state)
        ARB_NORMAL: begin
          if (acc_req && !acc_gnt) begin
            if (starve_cnt == CNT_LAST) begin
              state      <= ARB_FORCE;
              force_acc  <= 1'b1;
              starve_cnt <= '0;
            end else begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
          end else begin
            // A grant or an idle accelerator ends the starvation run.
            starve_cnt <= '0;
          end
        end
        ARB_FORCE: begin
          state      <= ARB_NORMAL;
          force_acc  <= 1'b0;
          starve_cnt <= '0;
        end
        default: begin
          state      <= ARB_NORMAL;
          force_acc  <= 1'b0;
          starve_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data BRAM arbiter between the CPU mem/wb stage (fixed
// priority) and the NN accelerator load/store port, with starvation-
// forced accelerator grants and owner-tagged read return.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DMEM_ADDR_W,
  parameter int unsigned DATA_W     = DMEM_DATA_W,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU side
  input  logic              cpu_ren,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // Accelerator side
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  output logic [DATA_W-1:0] acc_rdata,
  // BRAM side
  output logic              mem_ren,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic   cpu_act;
  logic   cpu_ok;
  logic   force_acc;
  logic   rd_pend;
  owner_t rd_owner;

  dmem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_req   (acc_req),
    .acc_gnt   (acc_gnt),
    .force_acc (force_acc)
  );

  // Grant equations: CPU wins unless a forced accelerator cycle is active.
  assign cpu_act   = cpu_ren | cpu_wren;
  assign acc_gnt   = acc_req & (~cpu_act | force_acc);
  assign cpu_stall = cpu_act & acc_gnt;
  assign cpu_ok    = cpu_act & ~acc_gnt;

  // BRAM port mux; a CPU store shadows a simultaneous CPU load.
  always_comb begin
    mem_ren   = 1'b0;
    mem_wren  = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (acc_gnt) begin
      mem_addr  = acc_addr;
      mem_wdata = acc_wdata;
      mem_wren  = acc_we;
      mem_ren   = ~acc_we;
    end else if (cpu_ok) begin
      mem_wren  = cpu_wren;
      mem_ren   = cpu_ren & ~cpu_wren;
    end
  end

  // Track who issued last cycle's read so the return can be tagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_CPU;
    end else begin
      rd_pend  <= mem_ren;
      rd_owner <= acc_gnt ? OWN_ACC : OWN_CPU;
    end
  end

  // Read data fans out to both requesters; only the accelerator gets a valid.
  assign acc_rvalid = rd_pend & (rd_owner == OWN_ACC);
  assign acc_rdata  = mem_rdata;
  assign cpu_rdata  = mem_rdata;

endmodule
